// File: rtl/booth_mult_seq_if.sv
// Handshake and operand/result bundle for the sequential Booth multiplier.
// The master side requests an operation; the slave side is the multiplier.
interface booth_mult_seq_if #(
   parameter int WIDTH = 8
);
   logic                   start;
   logic                   is_signed;
   logic [WIDTH-1:0]       mc;
   logic [WIDTH-1:0]       mp;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     product;

   modport master (
      output start, is_signed, mc, mp,
      input  busy, done, product
   );

   modport slave (
      input  start, is_signed, mc, mp,
      output busy, done, product
   );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier, radix-2 or radix-4, signed or unsigned per
// operation. Operands are extended to WIDTH+1 bits so full-range unsigned
// values multiply exactly. The accumulator carries two guard bits above the
// extended operand so that adding +/-2M never overflows.
module booth_mult_seq #(
   parameter int WIDTH  = 8,
   parameter int RADIX4 = 0
) (
   input  logic             clk,
   input  logic             reset,
   booth_mult_seq_if.slave  bus
);

   localparam int EXT_W = WIDTH + 1;
   localparam int N_IT  = (RADIX4 != 0) ? (EXT_W + 1) / 2 : EXT_W;
   localparam int QW    = (RADIX4 != 0) ? 2 * N_IT : N_IT;
   localparam int AW    = WIDTH + 3;
   localparam int PW    = AW + QW + 1;
   localparam int SH    = (RADIX4 != 0) ? 2 : 1;
   localparam int CW    = 6;
   localparam logic [CW-1:0] LAST_CNT = CW'(N_IT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_r;
   state_t               state_nx_s;
   logic                 busy_r;
   logic                 done_r;
   logic [AW-1:0]        a_r;
   logic [QW-1:0]        q_r;
   logic                 qm1_r;
   logic [AW-1:0]        m_r;
   logic [CW-1:0]        cnt_r;
   logic [2*WIDTH-1:0]   product_r;

   logic [AW-1:0]        addend_s;
   logic [AW-1:0]        sum_s;
   logic [PW-1:0]        shifted_s;
   logic                 last_s;
   logic                 ext_mc_s;
   logic                 ext_mp_s;

   // Radix-2 recoding: {q0, q-1} selects +M, -M or nothing.
   function automatic logic [AW-1:0] r2_addend(input logic [1:0] pair,
                                               input logic [AW-1:0] m);
      logic [AW-1:0] res;
      case (pair)
         2'b01:   res = m;
         2'b10:   res = -m;
         default: res = {AW{1'b0}};
      endcase
      return res;
   endfunction

   // Radix-4 recoding: {q1, q0, q-1} selects 0, +/-M or +/-2M.
   function automatic logic [AW-1:0] r4_addend(input logic [2:0] trip,
                                               input logic [AW-1:0] m);
      logic [AW-1:0] res;
      logic [AW-1:0] m2;
      m2 = {m[AW-2:0], 1'b0};
      case (trip)
         3'b001, 3'b010: res = m;
         3'b011:         res = m2;
         3'b100:         res = -m2;
         3'b101, 3'b110: res = -m;
         default:        res = {AW{1'b0}};
      endcase
      return res;
   endfunction

   assign last_s   = (cnt_r == LAST_CNT);
   assign ext_mc_s = bus.is_signed & bus.mc[WIDTH-1];
   assign ext_mp_s = bus.is_signed & bus.mp[WIDTH-1];

   // One Booth step: recode, add into the upper part, then shift the whole
   // {accumulator, multiplier, q-1} register arithmetically right.
   always_comb begin
      addend_s = {AW{1'b0}};
      if (RADIX4 != 0) begin
         addend_s = r4_addend({q_r[1], q_r[0], qm1_r}, m_r);
      end else begin
         addend_s = r2_addend({q_r[0], qm1_r}, m_r);
      end
      sum_s     = a_r + addend_s;
      shifted_s = $signed({sum_s, q_r, qm1_r}) >>> SH;
   end

   // Next-state decode for the IDLE / CALC / DONE controller.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) state_nx_s = ST_CALC;
            else           state_nx_s = ST_IDLE;
         end
         ST_CALC: begin
            if (last_s) state_nx_s = ST_DONE;
            else        state_nx_s = ST_CALC;
         end
         ST_DONE: begin
            if (bus.start) state_nx_s = ST_CALC;
            else           state_nx_s = ST_IDLE;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register with busy/done registered from the next state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= (state_nx_s == ST_CALC);
         done_r  <= (state_nx_s == ST_DONE);
      end
   end

   // Datapath: latch operands on acceptance, iterate in CALC, publish result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_r       <= {AW{1'b0}};
         q_r       <= {QW{1'b0}};
         qm1_r     <= 1'b0;
         m_r       <= {AW{1'b0}};
         cnt_r     <= {CW{1'b0}};
         product_r <= {(2*WIDTH){1'b0}};
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  a_r   <= {AW{1'b0}};
                  q_r   <= {{(QW-WIDTH){ext_mp_s}}, bus.mp};
                  qm1_r <= 1'b0;
                  m_r   <= {{(AW-WIDTH){ext_mc_s}}, bus.mc};
                  cnt_r <= {CW{1'b0}};
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            ST_CALC: begin
               {a_r, q_r, qm1_r} <= shifted_s;
               cnt_r             <= cnt_r + CW'(1);
               if (last_s) begin
                  product_r <= shifted_s[2*WIDTH:1];
               end else begin
                  product_r <= product_r;
               end
            end
            default: begin
               cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.product = product_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: four instances (W=8/5 x radix-2/4) driven from one
// directed sequence, checked against an integer-arithmetic reference model.
module tb_booth_mult_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  start_v = 4'b0000;
   logic        sg = 1'b0;
   logic [7:0]  mc_v = 8'h00;
   logic [7:0]  mp_v = 8'h00;
   logic [3:0]  busy_v;
   logic [3:0]  done_v;
   logic [15:0] prod_v [4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   booth_mult_seq_if #(.WIDTH(8)) if0 ();
   booth_mult_seq_if #(.WIDTH(8)) if1 ();
   booth_mult_seq_if #(.WIDTH(5)) if2 ();
   booth_mult_seq_if #(.WIDTH(5)) if3 ();

   booth_mult_seq #(.WIDTH(8), .RADIX4(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
   booth_mult_seq #(.WIDTH(8), .RADIX4(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   booth_mult_seq #(.WIDTH(5), .RADIX4(0)) dut2 (.clk(clk), .reset(reset), .bus(if2));
   booth_mult_seq #(.WIDTH(5), .RADIX4(1)) dut3 (.clk(clk), .reset(reset), .bus(if3));

   assign if0.start = start_v[0];
   assign if1.start = start_v[1];
   assign if2.start = start_v[2];
   assign if3.start = start_v[3];
   assign if0.is_signed = sg;
   assign if1.is_signed = sg;
   assign if2.is_signed = sg;
   assign if3.is_signed = sg;
   assign if0.mc = mc_v;
   assign if1.mc = mc_v;
   assign if2.mc = mc_v[4:0];
   assign if3.mc = mc_v[4:0];
   assign if0.mp = mp_v;
   assign if1.mp = mp_v;
   assign if2.mp = mp_v[4:0];
   assign if3.mp = mp_v[4:0];
   assign busy_v = {if3.busy, if2.busy, if1.busy, if0.busy};
   assign done_v = {if3.done, if2.done, if1.done, if0.done};
   assign prod_v[0] = if0.product;
   assign prod_v[1] = if1.product;
   assign prod_v[2] = {6'b000000, if2.product};
   assign prod_v[3] = {6'b000000, if3.product};

   int w_of [4] = '{8, 8, 5, 5};
   int r_of [4] = '{0, 1, 0, 1};

   // Exact product of two w-bit operands, reduced to 2w bits.
   function automatic logic [31:0] ref_prod(input int w, input logic [7:0] a,
                                            input logic [7:0] b, input logic s);
      longint av, bv, p;
      av = longint'(a) & ((64'sd1 << w) - 1);
      bv = longint'(b) & ((64'sd1 << w) - 1);
      if (s && av[w-1]) av = av - (64'sd1 << w);
      if (s && bv[w-1]) bv = bv - (64'sd1 << w);
      p = av * bv;
      return 32'(p & ((64'sd1 << (2 * w)) - 1));
   endfunction

   // Cycles from the accepting edge to done: iterations plus one.
   function automatic int exp_lat(input int w, input int r);
      return (r != 0) ? ((w + 2) / 2) + 1 : w + 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic s, output logic [15:0] p, output int lat);
      mc_v = a;
      mp_v = b;
      sg = s;
      start_v[d] = 1'b1;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         start_v[d] = 1'b0;
         lat++;
      end while (!done_v[d] && lat < 60);
      p = prod_v[d];
   endtask

   task automatic verify_op(input int d, input logic [7:0] a, input logic [7:0] b,
                            input logic s);
      logic [15:0] p;
      int lat;
      run_op(d, a, b, s, p, lat);
      check($sformatf("prod_d%0d_%0h_%0h_%0d", d, a, b, s), p, ref_prod(w_of[d], a, b, s));
      check($sformatf("lat_d%0d", d), lat, exp_lat(w_of[d], r_of[d]));
   endtask

   initial begin
      logic [15:0] p;
      int lat;
      int dn;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         check($sformatf("rst_busy_d%0d", d), busy_v[d], 1'b0);
         check($sformatf("rst_done_d%0d", d), done_v[d], 1'b0);
         check($sformatf("rst_prod_d%0d", d), prod_v[d], 16'h0000);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;

      // -3 * 5 signed, radix-2: busy for 9 cycles, done on the 10th
      mc_v = 8'hFD;
      mp_v = 8'h05;
      sg = 1'b1;
      start_v[0] = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         start_v[0] = 1'b0;
         check($sformatf("t1_busy_c%0d", c), busy_v[0], (c <= 9));
         check($sformatf("t1_done_c%0d", c), done_v[0], (c == 10));
         if (c == 5) check("t1_hold", prod_v[0], 16'h0000);
      end
      check("t1_prod", prod_v[0], 16'hFFF1);

      // Full-range operands, both signedness modes
      run_op(0, 8'hFF, 8'hFF, 1'b0, p, lat);
      check("t2_unsigned", p, 16'hFE01);
      run_op(0, 8'hFF, 8'hFF, 1'b1, p, lat);
      check("t2_signed", p, 16'h0001);

      // Radix-4 corner operands
      run_op(1, 8'h7F, 8'h80, 1'b1, p, lat);
      check("t3_prod_a", p, 16'hC080);
      check("t3_lat", lat, 6);
      run_op(1, 8'h80, 8'h80, 1'b1, p, lat);
      check("t3_prod_b", p, 16'h4000);

      // Start pulses while busy are ignored; operands are latched
      mc_v = 8'h0C;
      mp_v = 8'h0B;
      sg = 1'b0;
      start_v[0] = 1'b1;
      dn = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         if (done_v[0]) dn++;
         if (c == 2 || c == 4) begin
            start_v[0] = 1'b1;
            mc_v = 8'(c * 37);
            mp_v = 8'h5A;
            sg = 1'b1;
         end else begin
            start_v[0] = 1'b0;
         end
         if (c == 10) check("t4_done_at_10", done_v[0], 1'b1);
      end
      check("t4_single_done", dn, 1);
      check("t4_prod", prod_v[0], 16'h0084);
      // start raised during the DONE cycle: accepted back-to-back
      run_op(0, 8'h13, 8'h07, 1'b1, p, lat);
      check("t4_b2b_prod", p, 16'h0085);
      check("t4_b2b_lat", lat, 10);
      @(posedge clk);
      #1;
      check("t4_no_queue", busy_v[0], 1'b0);

      // Reset mid-calculation aborts the operation
      mc_v = 8'h21;
      mp_v = 8'h03;
      sg = 1'b0;
      start_v[0] = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk);
         #1;
         start_v[0] = 1'b0;
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("t5_busy", busy_v[0], 1'b0);
      check("t5_done", done_v[0], 1'b0);
      check("t5_prod", prod_v[0], 16'h0000);
      reset = 1'b1;
      dn = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk);
         #1;
         if (done_v[0]) dn++;
      end
      check("t5_no_done", dn, 0);
      verify_op(0, 8'h21, 8'h03, 1'b0);

      // Exhaustive sweep for W=5, both radices and both signedness modes
      for (int d = 2; d < 4; d++) begin
         for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 32; a++) begin
               for (int b = 0; b < 32; b++) begin
                  verify_op(d, 8'(a), 8'(b), s[0]);
               end
            end
         end
      end

      // Random sweep for W=8, both radices, alternating signedness
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 2000; i++) begin
            verify_op(d, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i[0]);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
